// File: rtl/seq_detect_pkg.sv
// Shared encodings for the "101" sequence detector and its session controller.
// Detector and controller states are both 2-bit enums.
package seq_detect_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_GOT1  = 2'b01,
      S_GOT10 = 2'b10
   } det_t;

   typedef enum logic [1:0] {
      C_IDLE = 2'b00,
      C_RUN  = 2'b01,
      C_DONE = 2'b10
   } ctrl_t;

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Serial bit stream and result port of the "101" session controller.
// master = bit source / host side, slave = controller side.
interface seq_detect_ctrl_if #(
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in;
   logic             in_ready;
   logic             res_valid;
   logic             res_ready;
   logic [CNT_W-1:0] res_count;
   logic             res_timeout;

   modport master (
      output in_valid, in, res_ready,
      input  in_ready, res_valid, res_count, res_timeout
   );

   modport slave (
      input  in_valid, in, res_ready,
      output in_ready, res_valid, res_count, res_timeout
   );
endinterface

// File: rtl/seq101_next.sv
// Combinational next-state and match logic of the "101" detector.
// SEQ_OVERLAP_EN: after a match, the trailing 1 seeds the next pattern.
module seq101_next
   import seq_detect_pkg::*;
(
   input  logic [1:0] state,
   input  logic       din,
   input  logic       valid,
   output det_t       nxt,
   output logic       match
);

`ifdef SEQ_OVERLAP_EN
   localparam det_t POST_MATCH = S_GOT1;
`else
   localparam det_t POST_MATCH = S_IDLE;
`endif

   always_comb begin
      nxt   = S_IDLE;
      match = 1'b0;
      case (state)
         S_IDLE:  nxt = (valid && din) ? S_GOT1 : S_IDLE;
         S_GOT1:  nxt = (valid && !din) ? S_GOT10 : S_GOT1;
         S_GOT10: begin
            if (!valid) begin
               nxt = S_GOT10;
            end else if (din) begin
               nxt   = POST_MATCH;
               match = 1'b1;
            end else begin
               nxt = S_IDLE;
            end
         end
         default: nxt = S_IDLE;
      endcase
   end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Session controller for the "101" detector: arms, counts, times out, reports.
// Build option SEQ_OVERLAP_EN selects overlapping detection (in seq101_next).
module seq_detect_ctrl
   import seq_detect_pkg::*;
#(
   parameter int CNT_W = 8,
   parameter int TMO_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] target,
   input  logic [TMO_W-1:0] timeout,
   output logic             busy,
   output logic [1:0]       det_state,
   output logic             det_pulse,
   seq_detect_ctrl_if.slave io
);

   ctrl_t            c_q, c_d;
   det_t             det_q, det_d, nxt;
   logic [CNT_W-1:0] cnt_q, cnt_d, tgt_q, tgt_d, cnt_inc;
   logic [TMO_W-1:0] tmr_q, tmr_d, tmo_q, tmo_d;
   logic             pulse_d, pulse_q;
   logic             rto_d, rto_q;
   logic             busy_q;
   logic             match;

   seq101_next u_next (
      .state (det_q),
      .din   (io.in),
      .valid (io.in_valid && (c_q == C_RUN)),
      .nxt   (nxt),
      .match (match)
   );

   assign cnt_inc = cnt_q + 1'b1;

   always_comb begin
      c_d     = c_q;
      det_d   = det_q;
      cnt_d   = cnt_q;
      tgt_d   = tgt_q;
      tmr_d   = tmr_q;
      tmo_d   = tmo_q;
      rto_d   = rto_q;
      pulse_d = 1'b0;
      unique case (c_q)
         C_IDLE: begin
            if (start) begin
               tgt_d = target;
               tmo_d = timeout;
               cnt_d = '0;
               tmr_d = '0;
               rto_d = 1'b0;
               det_d = S_IDLE;
               c_d   = (target == '0) ? C_DONE : C_RUN;
            end
         end
         C_RUN: begin
            det_d = nxt;
            tmr_d = tmr_q + 1'b1;
            if (match) begin
               cnt_d   = cnt_inc;
               pulse_d = 1'b1;
            end
            // A completing match beats a timeout landing on the same cycle
            if (match && (cnt_inc == tgt_q)) begin
               c_d   = C_DONE;
               rto_d = 1'b0;
            end else if ((tmo_q != '0) && (tmr_q == tmo_q - 1'b1)) begin
               c_d   = C_DONE;
               rto_d = 1'b1;
            end
         end
         C_DONE: begin
            if (io.res_ready) c_d = C_IDLE;
         end
         default: c_d = C_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         c_q     <= C_IDLE;
         det_q   <= S_IDLE;
         cnt_q   <= '0;
         tgt_q   <= '0;
         tmr_q   <= '0;
         tmo_q   <= '0;
         rto_q   <= 1'b0;
         pulse_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         c_q     <= c_d;
         det_q   <= det_d;
         cnt_q   <= cnt_d;
         tgt_q   <= tgt_d;
         tmr_q   <= tmr_d;
         tmo_q   <= tmo_d;
         rto_q   <= rto_d;
         pulse_q <= pulse_d;
         busy_q  <= (c_d != C_IDLE);
      end
   end

   assign busy           = busy_q;
   assign det_state      = det_q;
   assign det_pulse      = pulse_q;
   assign io.in_ready    = (c_q == C_RUN);
   assign io.res_valid   = (c_q == C_DONE);
   assign io.res_count   = cnt_q;
   assign io.res_timeout = rto_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: directed scenarios then random traffic,
// every cycle compared against a pattern-matching session model.
module tb_seq_detect_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  target;
   logic [15:0] timeout;
   logic        busy;
   logic [1:0]  det_state;
   logic        det_pulse;

   seq_detect_ctrl_if #(.CNT_W(8)) io ();

   seq_detect_ctrl #(.CNT_W(8), .TMO_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .target    (target),
      .timeout   (timeout),
      .busy      (busy),
      .det_state (det_state),
      .det_pulse (det_pulse),
      .io        (io.slave)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
   endtask

   // Session model: phase 0 idle, 1 running, 2 result pending.
   int m_phase, m_count, m_tgt, m_tmo, m_elapsed, m_rto, m_pulse;
   int q[$];

   function automatic logic [1:0] q_state();
      if (q.size() >= 2 && q[q.size()-2] == 1 && q[q.size()-1] == 0)
         return 2'b10;
      if (q.size() >= 1 && q[q.size()-1] == 1)
         return 2'b01;
      return 2'b00;
   endfunction

   task automatic step(input logic s, input int tg, input int to,
                       input logic v, input logic b, input logic rr,
                       input logic r);
      bit hit;
      m_pulse = 0;
      if (r) begin
         m_phase = 0; m_count = 0; m_tgt = 0; m_tmo = 0;
         m_elapsed = 0; m_rto = 0;
         q.delete();
         return;
      end
      case (m_phase)
         0: if (s) begin
            m_tgt = tg; m_tmo = to; m_count = 0;
            m_elapsed = 0; m_rto = 0;
            q.delete();
            m_phase = (tg == 0) ? 2 : 1;
         end
         1: begin
            hit = 0;
            if (v) begin
               q.push_back(int'(b));
               if (q.size() > 3) void'(q.pop_front());
               if (q.size() == 3 && q[0] == 1 && q[1] == 0 && q[2] == 1)
                  hit = 1;
            end
            m_elapsed++;
            if (hit) begin
               m_count++;
               m_pulse = 1;
               q.delete();
`ifdef SEQ_OVERLAP_EN
               q.push_back(1);
`endif
            end
            if (hit && m_count == m_tgt) begin
               m_phase = 2; m_rto = 0;
            end else if (m_tmo != 0 && m_elapsed == m_tmo) begin
               m_phase = 2; m_rto = 1;
            end
         end
         default: if (rr) m_phase = 0;
      endcase
   endtask

   task automatic cyc(input logic s, input int tg, input int to,
                      input logic v, input logic b, input logic rr,
                      input logic r);
      start = s; target = 8'(tg); timeout = 16'(to);
      io.in_valid = v; io.in = b; io.res_ready = rr; rst = r;
      step(s, tg, to, v, b, rr, r);
      @(posedge clk);
      #1;
      chk("busy", busy, m_phase != 0);
      chk("in_ready", io.in_ready, m_phase == 1);
      chk("res_valid", io.res_valid, m_phase == 2);
      chk("res_count", io.res_count, m_count);
      chk("res_timeout", io.res_timeout, m_rto);
      chk("det_state", det_state, q_state());
      chk("det_pulse", det_pulse, m_pulse);
   endtask

   task automatic feed(input logic v, input logic b, input logic rr);
      cyc(0, 0, 0, v, b, rr, 0);
   endtask

   task automatic go(input int tg, input int to);
      cyc(1, tg, to, 0, 0, 0, 0);
   endtask

   initial begin
      start = 0; target = 0; timeout = 0; rst = 1;
      io.in_valid = 0; io.in = 0; io.res_ready = 0;
      cyc(0, 0, 0, 0, 0, 0, 1);
      chk("reset_busy", busy, 0);

      go(3, 0); feed(1, 1, 0); feed(1, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1);
      chk("rst_det", det_state, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid", io.res_valid, 0);
      chk("rst_cnt", io.res_count, 0);

      go(1, 0); feed(1, 1, 0); feed(1, 0, 0); feed(1, 1, 0);
      chk("basic_pulse", det_pulse, 1);
      chk("basic_valid", io.res_valid, 1);
      chk("basic_cnt", io.res_count, 1);
      chk("basic_to", io.res_timeout, 0);
      feed(0, 0, 1);

      go(2, 0);
      feed(1, 1, 0); feed(1, 0, 0); feed(1, 1, 0); feed(1, 0, 0);
      feed(1, 1, 0);
`ifdef SEQ_OVERLAP_EN
      chk("ovl_valid", io.res_valid, 1);
      chk("ovl_cnt", io.res_count, 2);
`else
      chk("ovl_wait", io.res_valid, 0);
      feed(1, 0, 0); feed(1, 1, 0);
      chk("ovl_valid", io.res_valid, 1);
      chk("ovl_cnt", io.res_count, 2);
`endif
      chk("ovl_to", io.res_timeout, 0);
      feed(0, 0, 1);

      go(2, 5);
      repeat (4) feed(0, 0, 0);
      chk("tmo_early", io.res_valid, 0);
      feed(0, 0, 0);
      chk("tmo_valid", io.res_valid, 1);
      chk("tmo_flag", io.res_timeout, 1);
      chk("tmo_cnt", io.res_count, 0);

      for (int i = 0; i < 4; i++) begin
         cyc(i[0], 1, 0, 0, 0, 0, 0);
         chk("bp_valid", io.res_valid, 1);
         chk("bp_flag", io.res_timeout, 1);
      end
      cyc(1, 2, 0, 0, 0, 1, 0);
      chk("bp_idle", io.res_valid, 0);
      chk("bp_busy", busy, 0);
      go(0, 0);
      chk("zero_valid", io.res_valid, 1);
      chk("zero_cnt", io.res_count, 0);
      feed(0, 0, 1);

      go(1, 3); feed(1, 1, 0); feed(1, 0, 0); feed(1, 1, 0);
      chk("sim_valid", io.res_valid, 1);
      chk("sim_to", io.res_timeout, 0);
      chk("sim_cnt", io.res_count, 1);
      feed(0, 0, 1);

      repeat (3000) begin
         cyc($urandom_range(0, 3) == 0,
             int'($urandom_range(0, 3)),
             int'($urandom_range(0, 12)),
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 1) == 1,
             $urandom_range(0, 2) == 0,
             $urandom_range(0, 199) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Session controller for the "101" serial sequence detector. It owns the detector state register and gates serial bits into it with a valid/ready handshake. It counts detections up to a programmed target, aborts on a cycle timeout, and returns the result through a valid/ready result port. It sits between a serial bit source and the host logic that arms detection sessions.

## Interface
- `CNT_W`, 8: width of target and detection count
- `TMO_W`, 16: width of timeout and cycle timer
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  arm a session; sampled only in C_IDLE
- `target`  in  CNT_W  detections required; latched on accepted start
- `timeout`  in  TMO_W  max C_RUN cycles; 0 disables; latched on accepted start
- `in_valid`  in  1  serial bit valid
- `in`  in  1  serial bit
- `in_ready`  out  1  bit accepted this cycle when `in_valid && in_ready`
- `busy`  out  1  high in C_RUN and C_DONE
- `det_state`  out  2  current detector state (S_IDLE=00, S_GOT1=01, S_GOT10=10)
- `det_pulse`  out  1  one-cycle pulse per detection
- `res_valid`  out  1  result available
- `res_ready`  in  1  result consumed when `res_valid && res_ready`
- `res_count`  out  CNT_W  detections in session
- `res_timeout`  out  1  session ended by timeout

## Operation
- Controller states: C_IDLE, C_RUN, C_DONE. Reset: C_IDLE; `det_state`=S_IDLE; all outputs 0; count and timer 0.
- C_IDLE: `in_ready`=0, `busy`=0. `start`=1 latches target/timeout, clears count, timer and `res_timeout`, forces `det_state`=S_IDLE, and enters C_RUN. If `target`=0, go directly to C_DONE with count 0 and `res_timeout`=0.
- C_RUN: `in_ready`=1, `busy`=1. An accepted bit advances the detector:
  - S_IDLE: 1→S_GOT1, 0→S_IDLE.
  - S_GOT1: 1→S_GOT1, 0→S_GOT10.
  - S_GOT10: 1→match, 0→S_IDLE.
  - 11: →S_IDLE, no match.
  - With no accepted bit, the detector holds.
- Match: count+1; `det_pulse` next cycle. Post-match state: S_IDLE (see Configuration).
- Completing match (count+1 == target): enter C_DONE, `res_timeout`=0.
- Timer: cleared on entry to C_RUN and increments every C_RUN cycle, valid or not. If `timeout`≠0, timer == timeout−1 and no completing match this cycle, enter C_DONE with `res_timeout`=1. A completing match in the same cycle wins (`res_timeout`=0).
- C_DONE: `res_valid`=1; `res_count`/`res_timeout` stable; `in_ready`=0; `start` ignored. Handshake → C_IDLE; `res_valid` low next cycle. Outputs `res_count`/`res_timeout` hold until the next accepted start.
- Count never exceeds target; no wrap.
- `rst` asserted mid-session: abandon immediately, no result produced, all reset values next cycle.

## Timing
- `start` at cycle t → `busy`=1, `in_ready`=1 at t+1.
- Bit accepted at t → `det_state`, count and `det_pulse` updated at t+1.
- Completing match at t → `res_valid` at t+1; `in_ready`=0 at t+1.
- Timeout: exactly `timeout` cycles in C_RUN; `res_valid` on the following cycle.
- Result accepted at t → C_IDLE at t+1. A `start` at t is ignored; the earliest new session is `start` at t+1.
- All outputs are registered except `in_ready` and `res_valid`, which decode the registered controller state.

## Configuration
- `SEQ_OVERLAP_EN` defined: a match moves the detector to S_GOT1, so the trailing 1 starts the next pattern (overlapping detection). Stream 1,0,1,0,1 gives 2 matches.
- Not defined: a match moves the detector to S_IDLE (non-overlapping). Same stream gives 1 match.

## Structure
- Package `seq_detect_pkg`: detector state encodings (S_IDLE, S_GOT1, S_GOT10) and controller state encodings (C_IDLE, C_RUN, C_DONE) as 2-bit constants/typedefs.
- Sub-module `seq101_next`: combinational next-state and match logic. Inputs: state, bit, valid. Outputs: next state, match. It honours `SEQ_OVERLAP_EN`. The controller holds all registers.

## Test plan
- Reset mid-session: `target`=3, feed 1,0 then `rst` → next cycle `det_state`=00, `busy`=0, `res_valid`=0, count 0.
- Basic: `target`=1, `timeout`=0, bits 1,0,1 on consecutive cycles → `det_pulse` one cycle after third bit; `res_valid`=1 with `res_count`=1, `res_timeout`=0.
- Overlap: `target`=2, stream 1,0,1,0,1 → with `SEQ_OVERLAP_EN`, `res_count`=2, no timeout. Without it, no result until a further 0,1 completes the second match.
- Timeout: `target`=2, `timeout`=5, `in_valid`=0 throughout → `res_valid` at 6th cycle after C_RUN entry, `res_count`=0, `res_timeout`=1.
- Simultaneous: `target`=1, `timeout`=3, bits 1,0,1 on the first 3 C_RUN cycles → `res_timeout`=0, `res_count`=1.
- Backpressure: hold `res_ready`=0 for 4 cycles with `start` pulsing → `res_valid` stays high, outputs stable, start ignored. `res_ready`=1 → C_IDLE next cycle; `target`=0 start → immediate result with count 0.
